regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; successor to the single-write, two-read file in the decode/writeback path.
- Adds configurable width, depth and port counts, same-cycle write-to-read forwarding, and a hardwired zero register.
- Adds a per-register busy scoreboard so decode can stall on registers with a pending producer.
- Sits between decode (read and issue ports) and writeback (write ports).

---
 rtl/regfile_mp.sv | 169 ++++++++++++++++
 tb/tb_regfile_mp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port integer register file with a per-register busy
//   scoreboard. Decode reads operands and issues destinations; writeback
//   drives the write ports.
//
//   Features:
//     - NRD combinational read ports, NWR write ports (higher index wins on
//       a same-address collision).
//     - Optional hardwired zero register (ZERO_REG).
//     - Optional same-cycle write-to-read bypass (FWD).
//     - Busy scoreboard: set on issue, cleared on write, cleared by flush.
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset (storage and scoreboard)
//     rd_addr   in   NRD*AW    read addresses, port i at [i*AW +: AW]
//     rd_data   out  NRD*XLEN  read data, combinational
//     rd_busy   out  NRD       addressed register has an unforwarded producer
//     wr_en     in   NWR       per-port write enable
//     wr_addr   in   NWR*AW    write addresses
//     wr_data   in   NWR*XLEN  write data
//     iss_en    in   1         mark iss_addr busy
//     iss_addr  in   AW        destination of the issuing instruction
//     flush     in   1         clear every busy bit
//     busy_vec  out  NREG      registered scoreboard state
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int FWD      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);

  // NREG may equal 2^AW, so the bound needs one extra bit.
  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // An address is usable when it names an implemented register that is not
  // the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < NREG_W);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage next state: ports scanned low to high so the highest index wins.
  // Decoding per register (rather than indexing by address) keeps
  // out-of-range addresses from ever touching the array.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)) &&
            addr_ok(wr_addr[j*AW +: AW])) begin
          regs_d[r] = wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state. Flush beats issue; issue beats a same-cycle write
  // because the newly issued producer supersedes the one completing now.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic wr_hit;
      wr_hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit = 1'b1;
        end
      end
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_en && (iss_addr == AW'(r)) && addr_ok(iss_addr)) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // ---------------------------------------------------------------------------
  // Read ports: stored value, optionally overridden by a matching write this
  // cycle. A forwarded read also hides the busy bit, since the producer's
  // result is on the wire right now.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] val;
      logic            bsy;
      ra  = rd_addr[i*AW +: AW];
      val = '0;
      bsy = 1'b0;
      if (addr_ok(ra)) begin
        for (int r = 0; r < NREG; r++) begin
          if (ra == AW'(r)) begin
            val = regs_q[r];
            bsy = busy_q[r];
          end
        end
        if (FWD != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
              val = wr_data[j*XLEN +: XLEN];
              bsy = 1'b0;
            end
          end
        end
      end
      rd_data[i*XLEN +: XLEN] = val;
      rd_busy[i]              = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp. Four instances share one set of inputs:
//     u_a  : forwarding on, zero register on, 32 regs, 2 write ports
//     u_nf : as u_a but forwarding off
//     u_nz : as u_a but no hardwired zero register
//     u_16 : as u_a but only 16 implemented registers
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;

  logic [NRD*XLEN-1:0] rd_data_a, rd_data_nf, rd_data_nz, rd_data_16;
  logic [NRD-1:0]      rd_busy_a, rd_busy_nf, rd_busy_nz, rd_busy_16;
  logic [31:0]         busy_vec_a, busy_vec_nf, busy_vec_nz;
  logic [15:0]         busy_vec_16;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .FWD(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_a));

  regfile_mp #(.XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .FWD(0)) u_nf (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nf),
    .rd_busy(rd_busy_nf), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_nf));

  regfile_mp #(.XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(0), .FWD(1)) u_nz (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .rd_busy(rd_busy_nz), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_nz));

  regfile_mp #(.XLEN(XLEN), .NREG(16), .AW(AW), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .FWD(1)) u_16 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_16),
    .rd_busy(rd_busy_16), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_16));

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1ns after it, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    tick();
    tick();
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr = {AW'(2*i+1), AW'(2*i)};
      #1;
      total++;
      if (rd_data_a !== 64'h0) $display("FAIL reset_read x%0d/x%0d: got %h expected 0", 2*i, 2*i+1, rd_data_a);
      else passed++;
    end
    total++;
    if (busy_vec_a !== 32'h0) $display("FAIL reset_busy: got %h expected 0", busy_vec_a);
    else passed++;
    // Write x5, then read it the following cycle.
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    tick();
    idle();
    rd_addr = {AW'(0), AW'(5)};
    #1;
    total++;
    if (rd_data_a[31:0] !== 32'hDEADBEEF) $display("FAIL write_x5: got %h expected deadbeef", rd_data_a[31:0]);
    else passed++;
  endtask

  task automatic test_forward();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(7)}; wr_data = {32'h0, 32'h12345678};
    rd_addr = {AW'(0), AW'(7)};
    #1;
    total++;
    if (rd_data_a[31:0] !== 32'h12345678) $display("FAIL fwd_same_cycle: got %h expected 12345678", rd_data_a[31:0]);
    else passed++;
    total++;
    if (rd_data_nf[31:0] !== 32'h0) $display("FAIL nofwd_same_cycle: got %h expected 0", rd_data_nf[31:0]);
    else passed++;
    tick();
    idle();
    total++;
    if (rd_data_nf[31:0] !== 32'h12345678) $display("FAIL nofwd_next_cycle: got %h expected 12345678", rd_data_nf[31:0]);
    else passed++;
  endtask

  task automatic test_zero_reg();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'hFFFFFFFF};
    iss_en = 1'b1; iss_addr = AW'(0);
    rd_addr = {AW'(0), AW'(0)};
    #1;
    total++;
    if (rd_data_a[31:0] !== 32'h0) $display("FAIL zero_no_fwd: got %h expected 0", rd_data_a[31:0]);
    else passed++;
    tick();
    idle();
    total++;
    if (rd_data_a[31:0] !== 32'h0) $display("FAIL zero_read: got %h expected 0", rd_data_a[31:0]);
    else passed++;
    total++;
    if (busy_vec_a[0] !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy_vec_a[0]);
    else passed++;
    total++;
    if (rd_data_nz[31:0] !== 32'hFFFFFFFF) $display("FAIL nozero_read: got %h expected ffffffff", rd_data_nz[31:0]);
    else passed++;
    // Issue and write in the same cycle: busy ends set.
    total++;
    if (busy_vec_nz[0] !== 1'b1) $display("FAIL nozero_busy: got %b expected 1", busy_vec_nz[0]);
    else passed++;
  endtask

  task automatic test_dual_write();
    wr_en = 2'b11; wr_addr = {AW'(3), AW'(3)}; wr_data = {32'h0000BBBB, 32'h0000AAAA};
    rd_addr = {AW'(0), AW'(3)};
    #1;
    total++;
    if (rd_data_a[31:0] !== 32'h0000BBBB) $display("FAIL dual_fwd: got %h expected 0000bbbb", rd_data_a[31:0]);
    else passed++;
    tick();
    idle();
    total++;
    if (rd_data_a[31:0] !== 32'h0000BBBB) $display("FAIL dual_store: got %h expected 0000bbbb", rd_data_a[31:0]);
    else passed++;
    total++;
    if (rd_data_nf[31:0] !== 32'h0000BBBB) $display("FAIL dual_store_nf: got %h expected 0000bbbb", rd_data_nf[31:0]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = AW'(9);
    tick();
    idle();
    rd_addr = {AW'(0), AW'(9)};
    #1;
    total++;
    if (busy_vec_a[9] !== 1'b1) $display("FAIL sb_issue_vec: got %b expected 1", busy_vec_a[9]);
    else passed++;
    total++;
    if (rd_busy_a[0] !== 1'b1) $display("FAIL sb_issue_rdbusy: got %b expected 1", rd_busy_a[0]);
    else passed++;
    // Writeback to x9: forwarded read hides busy; no-forward copy still stalls.
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h00000099};
    #1;
    total++;
    if (rd_busy_a[0] !== 1'b0) $display("FAIL sb_write_rdbusy: got %b expected 0", rd_busy_a[0]);
    else passed++;
    total++;
    if (rd_busy_nf[0] !== 1'b1) $display("FAIL sb_write_rdbusy_nf: got %b expected 1", rd_busy_nf[0]);
    else passed++;
    tick();
    idle();
    total++;
    if (busy_vec_a[9] !== 1'b0) $display("FAIL sb_write_clear: got %b expected 0", busy_vec_a[9]);
    else passed++;
    // Issue and write x9 together: busy stays set, data updated.
    iss_en = 1'b1; iss_addr = AW'(9);
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h000000AB};
    tick();
    idle();
    total++;
    if (busy_vec_a[9] !== 1'b1) $display("FAIL sb_iss_wr_busy: got %b expected 1", busy_vec_a[9]);
    else passed++;
    total++;
    if (rd_data_a[31:0] !== 32'h000000AB) $display("FAIL sb_iss_wr_data: got %h expected 000000ab", rd_data_a[31:0]);
    else passed++;
    // Issue x4 under flush: flush wins and clears x9 too.
    iss_en = 1'b1; iss_addr = AW'(4); flush = 1'b1;
    tick();
    idle();
    total++;
    if (busy_vec_a !== 32'h0) $display("FAIL sb_flush: got %h expected 0", busy_vec_a);
    else passed++;
  endtask

  task automatic test_range();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(20)}; wr_data = {32'h0, 32'h00000055};
    iss_en = 1'b1; iss_addr = AW'(20);
    rd_addr = {AW'(4), AW'(20)};
    #1;
    total++;
    if (rd_data_16[31:0] !== 32'h0) $display("FAIL range_fwd: got %h expected 0", rd_data_16[31:0]);
    else passed++;
    tick();
    idle();
    total++;
    if (rd_data_16 !== 64'h0) $display("FAIL range_read x20/x4: got %h expected 0", rd_data_16);
    else passed++;
    total++;
    if (rd_busy_16 !== 2'b00) $display("FAIL range_rdbusy: got %b expected 00", rd_busy_16);
    else passed++;
    total++;
    if (busy_vec_16 !== 16'h0) $display("FAIL range_busyvec: got %h expected 0", busy_vec_16);
    else passed++;
    total++;
    if (rd_data_a[31:0] !== 32'h00000055) $display("FAIL range_full_store: got %h expected 00000055", rd_data_a[31:0]);
    else passed++;
    flush = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(11)}; wr_data = {32'h0, 32'h00000077};
    iss_en = 1'b1; iss_addr = AW'(11);
    tick();
    idle();
    rd_addr = {AW'(5), AW'(11)};
    #1;
    total++;
    if (rd_data_a !== 64'h0) $display("FAIL rst_mid_data x11/x5: got %h expected 0", rd_data_a);
    else passed++;
    total++;
    if (busy_vec_a !== 32'h0) $display("FAIL rst_mid_busy: got %h expected 0", busy_vec_a);
    else passed++;
    total++;
    if (rd_data_nz[63:32] !== 32'h0) $display("FAIL rst_mid_nz_x5: got %h expected 0", rd_data_nz[63:32]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_zero_reg();
    test_dual_write();
    test_scoreboard();
    test_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
